// File: rtl/uart_echo_fifo.sv
// rtl/uart_echo_fifo.sv - receive byte FIFO and one-at-a-time transmit sequencer for the UART loopback

// Simple dual-port byte RAM with registered read, shaped for iCE40 BRAM inference.
// The read register returns the old contents when read and write hit the same address.
module uart_echo_fifo_ram #(
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data
);

  logic [7:0] mem [0:(1<<ADDR_W)-1];

  // Write port: no reset so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read port: one-cycle latency, only advances when the FIFO pops.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// Captures each rx_dv rising edge into the FIFO and hands bytes to the
// transmitter one at a time, waiting for tx_done between strobes.
module uart_echo_fifo #(
  parameter int DEPTH_LOG2 = 9
) (
  input  logic                  ICE_CLK,
  input  logic                  ICE_RST_N,
  input  logic                  rx_dv,
  input  logic [7:0]            rx_byte,
  input  logic                  tx_done,
  output logic                  tx_dv,
  output logic [7:0]            tx_byte,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  empty,
  output logic                  full,
  output logic                  overflow
);

  localparam int                   DEPTH      = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]  COUNT_FULL = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]  COUNT_ONE  = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t                 state_q;
  state_t                 state_d;
  logic                   rx_dv_q;
  logic                   wr_req;
  logic                   wr_accept;
  logic                   wr_drop;
  logic                   pop;
  logic                   load_tx;
  logic [DEPTH_LOG2-1:0]  wr_ptr;
  logic [DEPTH_LOG2-1:0]  rd_ptr;
  logic [7:0]             ram_dout;

  // A held-high rx_dv yields exactly one write on its rising edge.
  assign wr_req = rx_dv & ~rx_dv_q;

  // A pop at the same edge frees a slot, so a write while full still lands.
  assign wr_accept = wr_req & (~full | pop);
  assign wr_drop   = wr_req & full & ~pop;

  assign empty = (count == '0);
  assign full  = (count == COUNT_FULL);

  // Delayed copy of rx_dv for edge detection.
  always_ff @(posedge ICE_CLK or negedge ICE_RST_N) begin
    if (!ICE_RST_N) begin
      rx_dv_q <= 1'b0;
    end else begin
      rx_dv_q <= rx_dv;
    end
  end

  // Pointers wrap naturally; fullness is tracked by count, not pointer compare.
  always_ff @(posedge ICE_CLK or negedge ICE_RST_N) begin
    if (!ICE_RST_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_accept) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

  // Occupancy: a simultaneous accepted write and pop cancel out.
  always_ff @(posedge ICE_CLK or negedge ICE_RST_N) begin
    if (!ICE_RST_N) begin
      count <= '0;
    end else begin
      case ({wr_accept, pop})
        2'b10:   count <= count + COUNT_ONE;
        2'b01:   count <= count - COUNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Sticky overrun flag; only reset clears it.
  always_ff @(posedge ICE_CLK or negedge ICE_RST_N) begin
    if (!ICE_RST_N) begin
      overflow <= 1'b0;
    end else if (wr_drop) begin
      overflow <= 1'b1;
    end
  end

  uart_echo_fifo_ram #(
    .ADDR_W (DEPTH_LOG2)
  ) u_ram (
    .clk     (ICE_CLK),
    .wr_en   (wr_accept),
    .wr_addr (wr_ptr),
    .wr_data (rx_byte),
    .rd_en   (pop),
    .rd_addr (rd_ptr),
    .rd_data (ram_dout)
  );

  // Read sequencer state register.
  always_ff @(posedge ICE_CLK or negedge ICE_RST_N) begin
    if (!ICE_RST_N) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: pop when idle and data waits, strobe once, then wait for the
  // transmitter. tx_done is ignored while tx_dv is still high.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    load_tx = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        load_tx = 1'b1;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (!tx_dv && tx_done) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Transmit strobe and held byte; tx_byte only changes on the next load.
  always_ff @(posedge ICE_CLK or negedge ICE_RST_N) begin
    if (!ICE_RST_N) begin
      tx_dv   <= 1'b0;
      tx_byte <= 8'h00;
    end else begin
      tx_dv <= load_tx;
      if (load_tx) begin
        tx_byte <= ram_dout;
      end
    end
  end

endmodule

// File: tb/tb_uart_echo_fifo.sv
// tb/tb_uart_echo_fifo.sv - self-checking bench for uart_echo_fifo
module tb_uart_echo_fifo;

  localparam int DEPTH_LOG2 = 9;
  localparam int DEPTH      = 512;
  localparam int BIT_T      = 16;
  localparam int DRAIN_MAX  = 10000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_dv = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic       tx_done = 1'b0;
  logic       tx_dv;
  logic [7:0] tx_byte;
  logic [DEPTH_LOG2:0] count;
  logic       empty;
  logic       full;
  logic       overflow;

  uart_echo_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
    .ICE_CLK   (clk),
    .ICE_RST_N (rst_n),
    .rx_dv     (rx_dv),
    .rx_byte   (rx_byte),
    .tx_done   (tx_done),
    .tx_dv     (tx_dv),
    .tx_byte   (tx_byte),
    .count     (count),
    .empty     (empty),
    .full      (full),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: FIFO contents as a queue, sender as a ready/busy
  // timeline built from the documented latencies (pop -> strobe 1 edge later,
  // tx_done accepted no earlier than 3 edges after the pop).
  logic [7:0] m_q[$];
  int         m_edge;
  bit         m_wait;
  int         m_pop_e;
  int         m_tx_e;
  logic [7:0] m_pend;
  logic [7:0] m_tx_byte;
  bit         m_ovf;
  logic       m_prev_dv;
  bit         m_pop;
  bit         m_wr;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_q.delete();
        m_edge = 0; m_wait = 0; m_pop_e = -100; m_tx_e = -100;
        m_pend = 8'h00; m_tx_byte = 8'h00; m_ovf = 0; m_prev_dv = 1'b0;
      end else begin
        m_edge++;
        if (m_edge == m_tx_e) m_tx_byte = m_pend;
        m_pop = !m_wait && (m_q.size() > 0);
        if (m_pop) begin
          m_pend  = m_q.pop_front();
          m_wait  = 1;
          m_pop_e = m_edge;
          m_tx_e  = m_edge + 1;
        end else if (m_wait && (m_edge >= m_pop_e + 3) && tx_done) begin
          m_wait = 0;
        end
        m_wr = rx_dv && !m_prev_dv;
        m_prev_dv = rx_dv;
        if (m_wr) begin
          if (m_q.size() < DEPTH) m_q.push_back(rx_byte);
          else m_ovf = 1;
        end
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        check("m_count",    32'(count),    32'(m_q.size()));
        check("m_empty",    32'(empty),    32'(m_q.size() == 0));
        check("m_full",     32'(full),     32'(m_q.size() == DEPTH));
        check("m_overflow", 32'(overflow), 32'(m_ovf));
        check("m_tx_dv",    32'(tx_dv),    32'(m_edge == m_tx_e));
        check("m_tx_byte",  32'(tx_byte),  32'(m_tx_byte));
      end
    end
  end

  // Observed strobes from the DUT.
  logic [7:0] obs[$];
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && tx_dv) obs.push_back(tx_byte);
    end
  end

  // Transmitter stand-in: returns a one-cycle tx_done tx_lat cycles after each
  // strobe, but only while tx_en is set.
  bit tx_en = 0;
  int tx_lat = 4;
  bit tx_pend = 0;
  int tx_cnt = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (tx_done) tx_done = 1'b0;
      if (tx_dv) begin
        tx_pend = 1;
        tx_cnt  = tx_lat;
      end else if (tx_pend && tx_en) begin
        if (tx_cnt <= 1) begin
          tx_done = 1'b1;
          tx_pend = 0;
        end else begin
          tx_cnt--;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic write_byte(input logic [7:0] b);
    @(negedge clk);
    rx_byte = b;
    rx_dv   = 1'b1;
    @(negedge clk);
    rx_dv   = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    tx_pend = 0;
    tx_done = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while ((m_q.size() != 0 || m_wait) && k < DRAIN_MAX) begin
      @(negedge clk);
      k++;
    end
    repeat (4) @(negedge clk);
    check(name, 32'(k < DRAIN_MAX), 32'd1);
  endtask

  logic [7:0] wrap_in[$];
  int base;

  initial begin
    // Reset values
    repeat (3) @(negedge clk);
    check("rst_tx_dv",    32'(tx_dv),    32'd0);
    check("rst_tx_byte",  32'(tx_byte),  32'h00);
    check("rst_count",    32'(count),    32'd0);
    check("rst_empty",    32'(empty),    32'd1);
    check("rst_full",     32'(full),     32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    rst_n = 1'b1;

    // Single byte, tx_done held low
    tx_en = 0; tx_lat = 4;
    base = obs.size();
    @(negedge clk);
    rx_byte = 8'hA5; rx_dv = 1'b1;
    @(negedge clk);
    rx_dv = 1'b0;
    check("single_count_w",  32'(count),   32'd1);
    @(negedge clk);
    check("single_dv_w1",    32'(tx_dv),   32'd0);
    check("single_count_w1", 32'(count),   32'd0);
    @(negedge clk);
    check("single_dv_w2",    32'(tx_dv),   32'd1);
    check("single_byte_w2",  32'(tx_byte), 32'hA5);
    @(negedge clk);
    check("single_dv_w3",    32'(tx_dv),   32'd0);
    repeat (20) @(negedge clk);
    check("single_pulses",   32'(obs.size() - base), 32'd1);
    tx_en = 1;
    repeat (12) @(negedge clk);
    check("single_empty",    32'(empty),   32'd1);
    check("single_pulses2",  32'(obs.size() - base), 32'd1);

    // Burst 01..10 at scaled baud spacing
    tx_lat = 10 * BIT_T;
    base = obs.size();
    for (int i = 1; i <= 16; i++) begin
      write_byte(8'(i));
      repeat (10 * BIT_T - 2) @(negedge clk);
    end
    drain("burst_drain");
    check("burst_pulses", 32'(obs.size() - base), 32'd16);
    for (int i = 1; i <= 16; i++) begin
      if (base + i - 1 < obs.size()) check("burst_order", 32'(obs[base+i-1]), 32'(i));
    end
    check("burst_count", 32'(count), 32'd0);

    // Overflow: 514 writes with the transmitter stalled
    do_reset();
    tx_en = 0; tx_lat = 4;
    base = obs.size();
    for (int i = 0; i < 513; i++) write_byte(8'(i));
    check("ovf_count_513", 32'(count),    32'd512);
    check("ovf_full_513",  32'(full),     32'd1);
    check("ovf_flag_513",  32'(overflow), 32'd0);
    write_byte(8'(513));
    check("ovf_count_514", 32'(count),    32'd512);
    check("ovf_flag_514",  32'(overflow), 32'd1);
    tx_en = 1;
    drain("ovf_drain");
    check("ovf_sent", 32'(obs.size() - base), 32'd513);
    if (obs.size() > base) check("ovf_first", 32'(obs[base]), 32'h00);
    if (obs.size() > base + 512) check("ovf_last", 32'(obs[base+512]), 32'h00);
    check("ovf_sticky", 32'(overflow), 32'd1);

    // Long rx_dv: one write only
    do_reset();
    tx_en = 0; tx_lat = 4;
    base = obs.size();
    write_byte(8'h77);
    repeat (3) @(negedge clk);
    check("long_count0", 32'(count), 32'd0);
    @(negedge clk);
    rx_byte = 8'h3C; rx_dv = 1'b1;
    repeat (20) @(negedge clk);
    rx_dv = 1'b0;
    @(negedge clk);
    check("long_count1", 32'(count), 32'd1);
    tx_en = 1;
    drain("long_drain");
    check("long_sent", 32'(obs.size() - base), 32'd2);
    if (obs.size() > base + 1) check("long_byte", 32'(obs[base+1]), 32'h3C);

    // Wrap-around: 600 bytes in two chunks, pointers pass 511
    tx_lat = 3;
    base = obs.size();
    for (int c = 0; c < 2; c++) begin
      tx_en = 0;
      for (int i = 0; i < 300; i++) begin
        wrap_in.push_back(8'((c * 300 + i) * 37 + 5));
        write_byte(8'((c * 300 + i) * 37 + 5));
      end
      tx_en = 1;
      drain("wrap_drain");
    end
    check("wrap_sent", 32'(obs.size() - base), 32'd600);
    for (int i = 0; i < 600; i++) begin
      if (base + i < obs.size()) check("wrap_order", 32'(obs[base+i]), 32'(wrap_in[i]));
    end

    // Reset mid-WAIT with five bytes queued
    tx_en = 0; tx_lat = 4;
    for (int i = 0; i < 6; i++) write_byte(8'(8'hC0 + i));
    repeat (3) @(negedge clk);
    check("midrst_count5", 32'(count), 32'd5);
    base = obs.size();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_tx_dv",    32'(tx_dv),    32'd0);
    check("midrst_tx_byte",  32'(tx_byte),  32'h00);
    check("midrst_count",    32'(count),    32'd0);
    check("midrst_empty",    32'(empty),    32'd1);
    check("midrst_full",     32'(full),     32'd0);
    check("midrst_overflow", 32'(overflow), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tx_en = 1;
    repeat (20) @(negedge clk);
    check("midrst_no_tx", 32'(obs.size() - base), 32'd0);
    check("midrst_empty2", 32'(empty), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
